// File: rtl/pending_encoder8to3.sv
// Sequential 8-to-3 encoder: request lines latch into a pending register and
// drain one binary index per accepted transfer, in fixed priority order, over valid/ready.
module pending_encoder8to3 #(
  parameter int PRIORITY_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       ready,
  output logic [2:0] Y,
  output logic       valid,
  output logic [7:0] pending,
  output logic [3:0] count,
  output logic       overflow
);

  logic [7:0] p_q;
  logic [7:0] p_d;
  logic [2:0] sel;
  logic       slot_free;
  logic       load;
  logic [7:0] load_mask;
  logic [7:0] slot_mask;
  logic [7:0] dup;

  // Later loop iterations win, so walk from lowest to highest priority.
  always_comb begin
    int unsigned idx;
    sel = '0;
    idx = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = (PRIORITY_HIGH != 0) ? i : 7 - i;
      if (p_q[idx]) sel = 3'(idx);
    end
  end

  always_comb begin
    slot_free = !valid || ready;
    load      = slot_free && (p_q != '0);
    load_mask = load ? (8'b1 << sel) : '0;
    slot_mask = (valid && !ready) ? (8'b1 << Y) : '0;
    dup       = req & ((p_q & ~load_mask) | slot_mask);
    // A request matching a stalled slot index merges into the slot, not into P.
    p_d       = (req & ~slot_mask) | (p_q & ~load_mask);
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      count = count + 4'(p_q[i]);
    end
  end

  assign pending = p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q      <= '0;
      Y        <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      p_q      <= p_d;
      overflow <= |dup;
      if (load) begin
        Y     <= sel;
        valid <= 1'b1;
      end else if (slot_free) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pending_encoder8to3.sv
// Directed, table-driven bench for pending_encoder8to3 (both priority orders).
module tb_pending_encoder8to3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = '0;
  logic       ready = 1'b0;

  logic [2:0] y_hi, y_lo;
  logic       v_hi, v_lo;
  logic [7:0] p_hi, p_lo;
  logic [3:0] c_hi, c_lo;
  logic       o_hi, o_lo;

  int checks = 0;
  int errors = 0;

  pending_encoder8to3 #(.PRIORITY_HIGH(1)) dut_hi (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .Y(y_hi), .valid(v_hi), .pending(p_hi), .count(c_hi), .overflow(o_hi)
  );

  pending_encoder8to3 #(.PRIORITY_HIGH(0)) dut_lo (
    .clk(clk), .rst(rst), .req(req), .ready(ready),
    .Y(y_lo), .valid(v_lo), .pending(p_lo), .count(c_lo), .overflow(o_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       ready;
    logic [2:0] y;
    logic       v;
    logic [7:0] p;
    logic [3:0] cnt;
    logic       ovf;
    logic       chk_lo;
    logic [2:0] ylo;
    logic       vlo;
    logic [7:0] plo;
  } vec_t;

  vec_t vec [33];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_y_hi"}, 8'(y_hi), 8'h0);
    chk({tag, "_v_hi"}, 8'(v_hi), 8'h0);
    chk({tag, "_p_hi"}, p_hi, 8'h0);
    chk({tag, "_c_hi"}, 8'(c_hi), 8'h0);
    chk({tag, "_o_hi"}, 8'(o_hi), 8'h0);
    chk({tag, "_y_lo"}, 8'(y_lo), 8'h0);
    chk({tag, "_v_lo"}, 8'(v_lo), 8'h0);
    chk({tag, "_p_lo"}, p_lo, 8'h0);
    chk({tag, "_c_lo"}, 8'(c_lo), 8'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            req    rdy y  v  p      cnt ovf lo ylo vlo plo
    // priority drain (lo instance checked here too)
    vec[0]  = '{8'hA4, 1, 0, 0, 8'hA4, 3, 0, 1, 0, 0, 8'hA4};
    vec[1]  = '{8'h00, 1, 7, 1, 8'h24, 2, 0, 1, 2, 1, 8'hA0};
    vec[2]  = '{8'h00, 1, 5, 1, 8'h04, 1, 0, 1, 5, 1, 8'h80};
    vec[3]  = '{8'h00, 1, 2, 1, 8'h00, 0, 0, 1, 7, 1, 8'h00};
    vec[4]  = '{8'h00, 1, 2, 0, 8'h00, 0, 0, 1, 7, 0, 8'h00};
    // backpressure, no preemption
    vec[5]  = '{8'h01, 0, 2, 0, 8'h01, 1, 0, 0, 0, 0, 8'h00};
    vec[6]  = '{8'h00, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    vec[7]  = '{8'h80, 0, 0, 1, 8'h80, 1, 0, 0, 0, 0, 8'h00};
    vec[8]  = '{8'h00, 0, 0, 1, 8'h80, 1, 0, 0, 0, 0, 8'h00};
    vec[9]  = '{8'h00, 0, 0, 1, 8'h80, 1, 0, 0, 0, 0, 8'h00};
    vec[10] = '{8'h00, 0, 0, 1, 8'h80, 1, 0, 0, 0, 0, 8'h00};
    vec[11] = '{8'h00, 0, 0, 1, 8'h80, 1, 0, 0, 0, 0, 8'h00};
    vec[12] = '{8'h00, 1, 7, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    vec[13] = '{8'h00, 1, 7, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    // duplicate of stalled slot index
    vec[14] = '{8'h08, 0, 7, 0, 8'h08, 1, 0, 0, 0, 0, 8'h00};
    vec[15] = '{8'h00, 0, 3, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    vec[16] = '{8'h08, 0, 3, 1, 8'h00, 0, 1, 0, 0, 0, 8'h00};
    vec[17] = '{8'h00, 0, 3, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    // duplicate of pending bit not being loaded
    vec[18] = '{8'h10, 0, 3, 1, 8'h10, 1, 0, 0, 0, 0, 8'h00};
    vec[19] = '{8'h10, 0, 3, 1, 8'h10, 1, 1, 0, 0, 0, 8'h00};
    vec[20] = '{8'h00, 1, 4, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    // re-request in the cycle the bit is loaded
    vec[21] = '{8'h20, 0, 4, 1, 8'h20, 1, 0, 0, 0, 0, 8'h00};
    vec[22] = '{8'h20, 1, 5, 1, 8'h20, 1, 0, 0, 0, 0, 8'h00};
    vec[23] = '{8'h00, 1, 5, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    vec[24] = '{8'h40, 1, 5, 0, 8'h40, 1, 0, 0, 0, 0, 8'h00};
    // accept Y=6 and re-request 6 in the same cycle
    vec[25] = '{8'h00, 1, 6, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    vec[26] = '{8'h40, 1, 6, 0, 8'h40, 1, 0, 0, 0, 0, 8'h00};
    vec[27] = '{8'h00, 1, 6, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    vec[28] = '{8'h00, 1, 6, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    // two duplicates in one cycle give one pulse
    vec[29] = '{8'h03, 0, 6, 0, 8'h03, 2, 0, 0, 0, 0, 8'h00};
    vec[30] = '{8'h00, 0, 1, 1, 8'h01, 1, 0, 0, 0, 0, 8'h00};
    vec[31] = '{8'h03, 0, 1, 1, 8'h01, 1, 1, 0, 0, 0, 8'h00};
    vec[32] = '{8'h00, 0, 1, 1, 8'h01, 1, 0, 0, 0, 0, 8'h00};

    #1 rst = 1'b1;
    #1 chk_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 33; i++) begin
      req   = vec[i].req;
      ready = vec[i].ready;
      step();
      chk($sformatf("r%0d_y", i),   8'(y_hi), 8'(vec[i].y));
      chk($sformatf("r%0d_v", i),   8'(v_hi), 8'(vec[i].v));
      chk($sformatf("r%0d_p", i),   p_hi,     vec[i].p);
      chk($sformatf("r%0d_cnt", i), 8'(c_hi), 8'(vec[i].cnt));
      chk($sformatf("r%0d_ovf", i), 8'(o_hi), 8'(vec[i].ovf));
      if (vec[i].chk_lo) begin
        chk($sformatf("r%0d_ylo", i), 8'(y_lo), 8'(vec[i].ylo));
        chk($sformatf("r%0d_vlo", i), 8'(v_lo), 8'(vec[i].vlo));
        chk($sformatf("r%0d_plo", i), p_lo,     vec[i].plo);
      end
    end

    // reset mid-drain with P=F0 and a stalled slot
    req = 8'h00; ready = 1'b1;
    step();
    chk("pre_y", 8'(y_hi), 8'h0);
    chk("pre_v", 8'(v_hi), 8'h1);
    req = 8'hF0; ready = 1'b0;
    step();
    chk("mid_p", p_hi, 8'hF0);
    chk("mid_v", 8'(v_hi), 8'h1);
    chk("mid_cnt", 8'(c_hi), 8'h4);
    #3 rst = 1'b1;
    #1 chk_reset("async");
    req = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post%0d_v_hi", k), 8'(v_hi), 8'h0);
      chk($sformatf("post%0d_v_lo", k), 8'(v_lo), 8'h0);
      chk($sformatf("post%0d_p_hi", k), p_hi, 8'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pending_encoder8to3.md
# pending_encoder8to3

Sequential 8-to-3 encoder, the inverse of the 3-to-8 decoder. It turns request bits on an 8-line bus back into 3-bit binary indices. Requests latch into a pending register and drain one index per accepted transfer, in fixed priority order, over a valid/ready output. It sits wherever decoded one-hot or multi-hot event lines must be converted back to binary codes for a downstream consumer that can stall.

## Interface
- PRIORITY_HIGH, default 1: 1 = bit 7 highest priority, bit 0 lowest; 0 = bit 0 highest, bit 7 lowest.

- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  request lines; each high bit is sampled every clk edge and sets the matching pending bit.
- ready  input  1  consumer accepts Y this cycle when valid && ready.
- Y  output  3  encoded index of the transfer in the output slot (registered).
- valid  output  1  output slot holds an index (registered).
- pending  output  8  pending request register, excluding the index in the output slot.
- count  output  4  population count of pending (0..8), combinational from pending.
- overflow  output  1  one-cycle registered pulse: a request was dropped as a duplicate.

## Operation
- State: pending register P[7:0], output slot (Y, valid), overflow flag.
- Slot free this cycle when valid == 0, or when valid && ready (transfer completes).
- Load on free slot:
  - If P != 0, select the highest-priority set bit of P (per PRIORITY_HIGH) as index s.
  - Y <= s, valid <= 1, and P[s] clears at the same edge. The index moves out of pending into the slot.
  - If P == 0, valid <= 0 and Y holds its last value.
- Selection uses only the registered P. A req arriving in the current cycle is not eligible until the next cycle; there is no bypass.
- P update per bit i, in priority order:
  - Set if req[i].
  - Else clear if i is being loaded into the slot.
  - Else hold.
- If req[i] is high in the same cycle P[i] moves into the slot, P[i] remains set. This is a new request, not a duplicate.
- Duplicate: req[i] is high and either condition holds:
  - P[i] is 1 and P[i] is not being loaded this cycle, or
  - valid && Y == i && !ready.
  
  The duplicate merges into existing state with no second entry. Overflow goes high for exactly the next cycle. Multiple duplicates in one cycle produce one pulse.
- No preemption: a higher-priority request never replaces an index already in the slot.
- While stalled (valid && !ready), Y and valid hold stable. P keeps accepting new requests.

## Timing
- Reset (async assert, any time): P = 0, Y = 3'd0, valid = 0, overflow = 0, count = 0. Any in-flight index is discarded. The first load can happen at the first clk edge after deassertion, once P becomes nonzero.
- Latency: req sampled at edge k sets P at edge k. With the slot free, valid/Y appear after edge k+1 (2 edges from req to valid).
- Throughput: one index per cycle with ready held high. Back-to-back transfers happen with no bubble while P != 0.
- Drain of n pending bits with ready = 1: valid is high for exactly n consecutive cycles, then low.
- count and pending reflect post-edge P. Overflow is asserted the cycle after the offending edge.

## Test plan
- Priority drain: PRIORITY_HIGH=1, reset, then req=8'b1010_0100 for one cycle, ready=1.
  - After edge 1: P=8'b1010_0100, count=3.
  - After edges 2, 3, 4: Y=7, 5, 2 with valid=1; P=8'b0010_0100, then 8'b0000_0100, then 0.
  - After edge 5: valid=0.
- Low-first priority: same stimulus with PRIORITY_HIGH=0 -> Y sequence 2, 5, 7.
- Backpressure, no preemption: ready=0, req=8'b0000_0001 -> Y=0, valid=1. Then req=8'b1000_0000 -> P=8'b1000_0000 while Y stays 0 for 5 stalled cycles. Then ready=1 -> Y=0 is accepted, next cycle Y=7, then valid=0.
- Duplicate/overflow:
  - With Y=3 valid and ready=0, pulse req=8'b0000_1000 -> overflow=1 for one cycle, P unchanged.
  - With P[4]=1 not being loaded, req[4] -> overflow pulse.
  - req[i] in the same cycle P[i] is loaded -> P[i] set, no overflow.
- Simultaneous accept and re-request: Y=6, valid=1, ready=1, req=8'b0100_0000 -> no overflow; index 6 is emitted again later.
- Reset mid-drain: assert rst asynchronously between edges with P=8'b1111_0000 and valid=1 -> all outputs go to reset values immediately. After release with req=0, valid stays 0.
